// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops bytes from the TX FIFO, frames them per the latched LCR fields
// and shifts them out one bit per OSR baud ticks; also derives the THRE/TEMT status bits.
module uart_tx_ctrl #(
  parameter int OSR = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic [1:0] lcr_wls,
  input  logic       lcr_stb,
  input  logic       lcr_pen,
  input  logic       lcr_eps,
  input  logic       lcr_stick,
  input  logic       lcr_break,
  input  logic       tx_fifo_empty,
  input  logic [7:0] tx_fifo_dout,
  output logic       tx_pop,
  output logic       tx,
  output logic       thre,
  output logic       temt,
  output logic       busy
);

  localparam int TW = $clog2(2 * OSR);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    wls_q;
  logic          stb_q, pen_q, par_q;
  logic          tx_q;
  logic          line_d;
  logic [TW-1:0] last_tick;
  logic [7:0]    word_mask;
  logic          load_par;

  // Parity is computed once at LOAD from the masked byte, so later LCR writes cannot disturb it.
  always_comb begin
    word_mask = 8'hFF >> (2'd3 - lcr_wls);
    if (lcr_stick)
      load_par = ~lcr_eps;
    else if (lcr_eps)
      load_par = ^(tx_fifo_dout & word_mask);
    else
      load_par = ~^(tx_fifo_dout & word_mask);
  end

  always_comb begin
    last_tick = TW'(OSR - 1);
    if (state_q == STOP && stb_q)
      last_tick = (wls_q == 2'd0) ? TW'(3 * OSR / 2 - 1) : TW'(2 * OSR - 1);
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: if (!tx_fifo_empty) state_d = LOAD;
      LOAD: begin
        shift_d = tx_fifo_dout;
        tick_d  = '0;
        bit_d   = '0;
        state_d = START;
      end
      default: begin
        if (baud_pulse) begin
          if (tick_q == last_tick) begin
            tick_d = '0;
            case (state_q)
              START: state_d = DATA;
              DATA: begin
                if (bit_q == ({1'b0, wls_q} + 3'd4)) begin
                  state_d = pen_q ? PARITY : STOP;
                end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                end
              end
              PARITY:  state_d = STOP;
              default: state_d = IDLE;
            endcase
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
    endcase

    // Line level for the state being entered, registered below so tx never glitches.
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
      PARITY:  line_d = par_q;
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wls_q   <= '0;
      stb_q   <= 1'b0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= lcr_break ? 1'b0 : line_d;
      if (state_q == LOAD) begin
        wls_q <= lcr_wls;
        stb_q <= lcr_stb;
        pen_q <= lcr_pen;
        par_q <= load_par;
      end
    end
  end

  assign tx     = tx_q;
  assign tx_pop = (state_q == IDLE) && !tx_fifo_empty;
  assign busy   = (state_q != IDLE);
  assign thre   = tx_fifo_empty;
  assign temt   = tx_fifo_empty && (state_q == IDLE);

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit sequencer for the UART. Pops bytes from the TX FIFO that the register block fills on THR writes, frames them according to the Line Control Register fields (word length, stop bits, parity, break), and shifts them onto the serial line, one bit per 16 baud ticks. It also produces the THRE/TEMT status bits for the LSR.

## Interface
Parameters:
- OSR, 16, baud_pulse ticks per bit time. Must be even and at least 4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- baud_pulse  in  1  one-clk oversampling tick from the divisor-latch baud generator
- lcr_wls  in  2  word length select; data bits = 5 + lcr_wls
- lcr_stb  in  1  stop-bit select
- lcr_pen  in  1  parity enable
- lcr_eps  in  1  even parity select
- lcr_stick  in  1  stick parity
- lcr_break  in  1  set break
- tx_fifo_empty  in  1  TX FIFO empty flag
- tx_fifo_dout  in  8  TX FIFO read data, valid the cycle after tx_pop
- tx_pop  out  1  one-cycle FIFO pop strobe
- tx  out  1  serial output, idle high
- thre  out  1  TX holding (FIFO) empty
- temt  out  1  transmitter fully empty
- busy  out  1  frame in progress

## Operation
- States: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE: if !tx_fifo_empty, assert tx_pop for exactly one cycle and go to LOAD. Otherwise stay.
- LOAD: capture tx_fifo_dout into the shift register. Latch lcr_wls, lcr_stb, lcr_pen, lcr_eps and lcr_stick into frame config. Clear tick_cnt and bit_cnt. Go to START.
- LCR changes during a frame have no effect on that frame. lcr_break is the only exception and is not latched.
- tick_cnt counts baud_pulse. A bit ends on the baud_pulse that brings the count to OSR; tick_cnt then clears.
- START: tx=0 for one bit, then DATA.
- DATA: shift out LSB first, 5+wls bits. The bit_cnt terminal value is wls+4. Then go to PARITY if pen is set, else STOP.
- PARITY bit value:
  - stick=0, eps=1: XOR of the transmitted data bits (even parity).
  - stick=0, eps=0: the inverse of that XOR (odd parity).
  - stick=1: ~eps.
  - Bits above the word length are excluded from the XOR.
- STOP: tx=1. Stop length depends on stb and wls:
  - stb=0: OSR ticks.
  - stb=1 with wls=00: 3*OSR/2 ticks.
  - stb=1 otherwise: 2*OSR ticks.
  - At the end of the stop period, go to IDLE.
- Break: while lcr_break=1, tx=0 in every state. The FSM keeps sequencing, so popped data is consumed.
- busy=1 in every state except IDLE.
- thre = tx_fifo_empty.
- temt = tx_fifo_empty & (state==IDLE).

## Timing
- Reset (rst low, asynchronous): state=IDLE, tx=1, tx_pop=0, busy=0, thre=1, temt=1, and all counters 0. A reset mid-frame drives tx high immediately and discards the frame.
- From IDLE with a non-empty FIFO:
  - tx_pop is high in cycle N.
  - LOAD is cycle N+1.
  - tx falls in cycle N+2 (first START cycle). This is independent of baud_pulse phase.
- Bit boundaries are aligned to baud_pulse edges. The first bit may be shorter than a nominal bit by up to one baud_pulse period. All subsequent bits are exactly OSR ticks.
- Frame length in ticks = OSR*(1 + data bits + pen) + stop ticks.
- Back-to-back frames: a non-empty FIFO at STOP exit gives tx_pop in the first IDLE cycle. The idle-high gap between frames is therefore 3 clk cycles plus phase alignment. There is no extra stop time.
- Simultaneous events:
  - A baud_pulse during LOAD is ignored.
  - A baud_pulse on the same cycle as the START entry counts.
  - tx_fifo_empty asserting while in LOAD has no effect; the data is already popped.
- tx is registered; it never glitches.
- thre and temt are combinational from tx_fifo_empty and state.

## Test plan
- Reset with rst=0 mid-frame (during DATA): tx=1, busy=0, thre=1, temt=1 asynchronously. After release, no tx_pop while the FIFO is empty.
- 8N1, byte 0x55, baud_pulse every 4 clk, OSR=16:
  - tx sequence is 0,1,0,1,0,1,0,1,0,1, each bit 16 ticks.
  - Exactly one tx_pop.
  - temt returns to 1 after the stop bit.
- 7E2, byte 0x7F (wls=10, pen=1, eps=1, stb=1):
  - Data bits 1111111, then parity 1, then 2 stop bits (32 ticks).
  - Bit 7 is not transmitted.
- 5-bit, stb=1, stick=1, eps=0, byte 0xE3:
  - Data bits 11000, then parity 1 (stick), then stop of 24 ticks.
- FIFO holding three bytes: three tx_pop pulses. Each inter-frame idle gap is no more than 3 clk plus one baud_pulse period. thre stays 0 until the last pop, then goes to 1. temt goes to 1 only after the final stop bit.
- lcr_break asserted mid-DATA for 20 ticks: tx=0 throughout. Changing lcr_wls mid-frame leaves the current frame's bit count unchanged and applies from the next frame.
